// File: rtl/t05_spi_bit_packer.sv
// MSB-first bit packer, byte FIFO and SPI mode-0 master for the compression output stage.
// Define T05_SPI_BITCOUNT_EN to append a 32-bit accepted-bit count trailer on flush.
module t05_spi_bit_packer #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [3:0]  HS_STATE   = 4'd5,
  parameter logic [3:0]  TL_STATE   = 4'd6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] en_state,
  input  logic       writeBit_HS,
  input  logic       writeEn_HS,
  input  logic       writeBit_TL,
  input  logic       writeEn_TL,
  input  logic       flush,
  output logic       bit_ready,
  output logic       sclk,
  output logic       mosi,
  output logic       cs_n,
  output logic       overflow,
  output logic       fin_state
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_LOW, S_HIGH, S_GAP
  } spi_st_t;

  logic [7:0]  pk_sh;
  logic [2:0]  pk_cnt;
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_full, fifo_empty;
  logic        sel_v, sel_b, acc;
  logic        push, pop;
  logic [7:0]  push_data, rd_data, pad_byte;
  logic        fl_pend, fl_done, fl_req;
  logic        svc_pad, svc_done;
  spi_st_t     st;
  logic [TW-1:0] tmr;
  logic        t_end;
  logic [2:0]  bcnt;
  logic [6:0]  tx_sh;

`ifdef T05_SPI_BITCOUNT_EN
  logic [31:0] bit_total, trl_word;
  logic [2:0]  trl_idx;
  logic [7:0]  trl_byte;
  logic        svc_trl;
  assign trl_word = bit_total >> {~trl_idx[1:0], 3'b000};
  assign trl_byte = trl_word[7:0];
`endif

  always_comb begin
    sel_v = 1'b0;
    sel_b = 1'b0;
    unique case (1'b1)
      (en_state == HS_STATE): begin
        sel_v = writeEn_HS;
        sel_b = writeBit_HS;
      end
      (en_state == TL_STATE): begin
        sel_v = writeEn_TL;
        sel_b = writeBit_TL;
      end
      default: ;
    endcase
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign bit_ready  = !fifo_full || (pk_cnt != 3'd7);
  assign acc        = sel_v && bit_ready;
  assign fl_req     = flush || fl_pend;
  assign pad_byte   = pk_sh << (4'd8 - {1'b0, pk_cnt});
  assign rd_data    = mem[rd_ptr[AW-1:0]];
  assign t_end      = (tmr == T_LAST);
  assign pop        = !fifo_empty &&
                      ((st == S_IDLE) || (st == S_GAP && t_end));

  // An incoming bit always wins the push slot; flush work waits for a quiet cycle.
  always_comb begin
    push      = 1'b0;
    push_data = {pk_sh[6:0], sel_b};
    svc_pad   = 1'b0;
    svc_done  = 1'b0;
`ifdef T05_SPI_BITCOUNT_EN
    svc_trl   = 1'b0;
`endif
    if (acc) begin
      push = (pk_cnt == 3'd7);
    end else if (fl_req) begin
      if (pk_cnt != 3'd0) begin
        push      = !fifo_full;
        push_data = pad_byte;
        svc_pad   = !fifo_full;
      end
`ifdef T05_SPI_BITCOUNT_EN
      else if (trl_idx != 3'd4) begin
        push      = !fifo_full;
        push_data = trl_byte;
        svc_trl   = !fifo_full;
      end
`endif
      else begin
        svc_done = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pk_sh     <= '0;
      pk_cnt    <= '0;
      fl_pend   <= 1'b0;
      fl_done   <= 1'b0;
      overflow  <= 1'b0;
      fin_state <= 1'b0;
`ifdef T05_SPI_BITCOUNT_EN
      bit_total <= '0;
      trl_idx   <= '0;
`endif
    end else begin
      if (sel_v && !bit_ready) overflow <= 1'b1;
      if (fl_done && fifo_empty && st == S_IDLE) fin_state <= 1'b1;
      if (acc) begin
        pk_sh     <= {pk_sh[6:0], sel_b};
        pk_cnt    <= pk_cnt + 3'd1;
        fl_done   <= 1'b0;
        fin_state <= 1'b0;
`ifdef T05_SPI_BITCOUNT_EN
        bit_total <= bit_total + 32'd1;
`endif
      end
      if (flush) begin
        fl_pend <= 1'b1;
        fl_done <= 1'b0;
      end
      if (svc_pad) pk_cnt <= '0;
`ifdef T05_SPI_BITCOUNT_EN
      if (svc_trl) trl_idx <= trl_idx + 3'd1;
      if (svc_done) trl_idx <= '0;
`endif
      if (svc_done) begin
        fl_pend <= 1'b0;
        fl_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st    <= S_IDLE;
      tmr   <= '0;
      bcnt  <= '0;
      tx_sh <= '0;
      sclk  <= 1'b0;
      mosi  <= 1'b0;
      cs_n  <= 1'b1;
    end else begin
      tmr <= t_end ? '0 : tmr + 1'b1;
      unique case (st)
        S_IDLE: begin
          tmr <= '0;
          if (pop) begin
            st    <= S_LOAD;
            tx_sh <= rd_data[6:0];
            mosi  <= rd_data[7];
            cs_n  <= 1'b0;
            bcnt  <= '0;
          end
        end
        S_LOAD, S_LOW: begin
          if (t_end) begin
            st   <= S_HIGH;
            sclk <= 1'b1;
          end
        end
        S_HIGH: begin
          if (t_end) begin
            sclk <= 1'b0;
            if (bcnt == 3'd7) begin
              st   <= S_GAP;
              cs_n <= 1'b1;
              mosi <= 1'b0;
            end else begin
              st    <= S_LOW;
              bcnt  <= bcnt + 3'd1;
              mosi  <= tx_sh[6];
              tx_sh <= {tx_sh[5:0], 1'b0};
            end
          end
        end
        S_GAP: begin
          if (t_end) begin
            if (pop) begin
              st    <= S_LOAD;
              tx_sh <= rd_data[6:0];
              mosi  <= rd_data[7];
              cs_n  <= 1'b0;
              bcnt  <= '0;
            end else begin
              st <= S_IDLE;
            end
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_t05_spi_bit_packer.sv
// Bench for t05_spi_bit_packer: vector table, random stream against a byte-level model,
// overflow burst and mid-frame reset sequences.
module tb_t05_spi_bit_packer;
  localparam int CD = 2;
  localparam int FD = 2;
  localparam logic [3:0] HS = 4'd5;
  localparam logic [3:0] TL = 4'd6;
  localparam int FRAME = 17 * CD;
  localparam int LIM = 8 * FRAME + 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] en_state = 4'd0;
  logic       writeBit_HS = 1'b0;
  logic       writeEn_HS = 1'b0;
  logic       writeBit_TL = 1'b0;
  logic       writeEn_TL = 1'b0;
  logic       flush = 1'b0;
  logic       bit_ready, sclk, mosi, cs_n, overflow, fin_state;

  always #5 clk = ~clk;

  t05_spi_bit_packer #(
    .CLK_DIV(CD), .FIFO_DEPTH(FD), .HS_STATE(HS), .TL_STATE(TL)
  ) dut (
    .clk(clk), .rst(rst), .en_state(en_state),
    .writeBit_HS(writeBit_HS), .writeEn_HS(writeEn_HS),
    .writeBit_TL(writeBit_TL), .writeEn_TL(writeEn_TL),
    .flush(flush), .bit_ready(bit_ready), .sclk(sclk),
    .mosi(mosi), .cs_n(cs_n), .overflow(overflow),
    .fin_state(fin_state)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  bit bits_q[$];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // SPI slave monitor: samples mosi on each rising sclk seen at negedge clk.
  bit in_frame = 0, prev_sclk = 0, prev_mosi = 0, mosi_bad = 0;
  int low_cyc = 0, rises = 0;
  logic [7:0] rx_sh = '0;
  always @(negedge clk) begin
    if (rst) begin
      in_frame = 0;
      prev_sclk = 0;
      prev_mosi = 0;
    end else begin
      if (!cs_n) begin
        if (!in_frame) begin
          in_frame = 1; low_cyc = 0; rises = 0;
          mosi_bad = 0; rx_sh = '0;
        end
        low_cyc++;
        if (sclk && mosi !== prev_mosi) mosi_bad = 1;
        if (sclk && !prev_sclk) begin
          rx_sh = {rx_sh[6:0], mosi};
          rises++;
        end
      end else if (in_frame) begin
        in_frame = 0;
        rx_q.push_back(rx_sh);
        check("frame_low_cycles", low_cyc, 16 * CD);
        check("frame_sclk_rises", rises, 8);
        check("frame_mosi_stable", mosi_bad, 0);
      end
      prev_sclk = sclk;
      prev_mosi = mosi;
    end
  end

  task automatic cyc(input logic [3:0] e, input logic hv, input logic hb,
                     input logic tv, input logic tb, input logic f);
    en_state = e;
    writeEn_HS = hv; writeBit_HS = hb;
    writeEn_TL = tv; writeBit_TL = tb;
    flush = f;
    @(posedge clk); #1;
    writeEn_HS = 0; writeEn_TL = 0; flush = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1; en_state = 0; flush = 0;
    writeEn_HS = 0; writeEn_TL = 0; writeBit_HS = 0; writeBit_TL = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    rx_q.delete();
  endtask

`ifdef T05_SPI_BITCOUNT_EN
  task automatic push_trailer(input int n);
    logic [31:0] c;
    c = n;
    for (int i = 3; i >= 0; i--) exp_q.push_back(c[8*i +: 8]);
  endtask
`endif

  task automatic compare_bytes(input string tag);
    check({tag, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < rx_q.size()) check({tag, "_byte"}, rx_q[i], exp_q[i]);
  endtask

  task automatic wait_fin(output int waited);
    waited = 0;
    while (!fin_state && waited < LIM) begin
      @(posedge clk); #1;
      waited++;
    end
  endtask

  typedef struct {
    logic [3:0] en;
    bit         use_hs;
    int         nbits;
    logic [7:0] pat;
    bit         fl;
    int         nexp;
    logic [7:0] b0;
    int         nacc;
  } vec_t;

  vec_t vt[7];
  vec_t v;
  int waited, nb, byte_v;
  logic [3:0] e;
  logic hv, hb, tv, tb, b;
  bit saw_low;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{TL,   0, 8, 8'hB2, 0, 1, 8'hB2, 8};
    vt[1] = '{HS,   1, 3, 8'hE0, 1, 1, 8'hE0, 3};
    vt[2] = '{HS,   0, 8, 8'hAA, 1, 0, 8'h00, 0};
    vt[3] = '{TL,   0, 8, 8'h5A, 0, 1, 8'h5A, 8};
    vt[4] = '{4'd0, 1, 8, 8'hFF, 0, 0, 8'h00, 0};
    vt[5] = '{TL,   0, 5, 8'hB0, 1, 1, 8'hB0, 5};
    vt[6] = '{HS,   1, 8, 8'h3C, 1, 1, 8'h3C, 8};

    do_reset();
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_cs_n", cs_n, 1);
    check("rst_bit_ready", bit_ready, 1);
    check("rst_overflow", overflow, 0);
    check("rst_fin", fin_state, 0);

    for (int r = 0; r < 7; r++) begin
      v = vt[r];
      do_reset();
      exp_q.delete();
      if (v.nexp > 0) exp_q.push_back(v.b0);
`ifdef T05_SPI_BITCOUNT_EN
      if (v.fl) push_trailer(v.nacc);
`endif
      for (int j = 0; j < v.nbits; j++)
        cyc(v.en, v.use_hs, v.pat[7-j], !v.use_hs, v.pat[7-j], 0);
      if (v.nbits == 8 && v.nexp > 0 && !v.fl) begin
        check("pack_lat_csn_high", cs_n, 1);
        @(posedge clk); #1;
        check("pack_lat_csn_low", cs_n, 0);
      end
      if (v.fl) begin
        cyc(v.en, 0, 0, 0, 0, 1);
        wait_fin(waited);
        check("fin_rise", fin_state, 1);
        check("frames_at_fin", rx_q.size(), exp_q.size());
        if (exp_q.size() == 0) check("fin_fast", waited <= 2, 1);
      end else begin
        idle(LIM);
        check("fin_no_flush", fin_state, 0);
      end
      idle(4);
      compare_bytes("vec");
      check("vec_overflow", overflow, 0);
    end

    // Random stream, one candidate bit every 5 cycles so the FIFO never fills.
    do_reset();
    bits_q.delete();
    for (int s = 0; s < 150; s++) begin
      byte_v = $urandom_range(2, 0);
      e = (byte_v == 0) ? HS : (byte_v == 1) ? TL : 4'd2;
      hv = $urandom_range(1, 0); hb = $urandom_range(1, 0);
      tv = $urandom_range(1, 0); tb = $urandom_range(1, 0);
      cyc(e, hv, hb, tv, tb, 0);
      if (e == HS && hv) bits_q.push_back(hb);
      if (e == TL && tv) bits_q.push_back(tb);
      idle(4);
    end
    b = $urandom_range(1, 0);
    cyc(TL, 0, 0, 1, b, 1);
    bits_q.push_back(b);
    exp_q.delete();
    nb = bits_q.size();
    for (int i = 0; i < nb; i += 8) begin
      byte_v = 0;
      for (int j = 0; j < 8; j++)
        byte_v = byte_v * 2 + ((i + j < nb) ? int'(bits_q[i+j]) : 0);
      exp_q.push_back(byte_v[7:0]);
    end
`ifdef T05_SPI_BITCOUNT_EN
    push_trailer(nb);
`endif
    wait_fin(waited);
    check("rand_fin", fin_state, 1);
    idle(4);
    compare_bytes("rand");
    check("rand_overflow", overflow, 0);

    // Back-to-back burst into a two-entry FIFO: only three whole bytes fit.
    do_reset();
    bits_q.delete();
    saw_low = 0;
    for (int i = 0; i < 40; i++) begin
      b = $urandom_range(1, 0);
      bits_q.push_back(b);
      en_state = TL; writeEn_TL = 1; writeBit_TL = b;
      @(negedge clk);
      if (!bit_ready) saw_low = 1;
      @(posedge clk); #1;
    end
    writeEn_TL = 0;
    check("ovf_ready_dropped", saw_low, 1);
    check("ovf_flag", overflow, 1);
    idle(5 * FRAME);
    exp_q.delete();
    for (int i = 0; i < 24; i += 8) begin
      byte_v = 0;
      for (int j = 0; j < 8; j++) byte_v = byte_v * 2 + int'(bits_q[i+j]);
      exp_q.push_back(byte_v[7:0]);
    end
    compare_bytes("ovf");
    check("ovf_fin", fin_state, 0);

    // Reset in the middle of a frame.
    do_reset();
    for (int j = 0; j < 8; j++) cyc(TL, 0, 0, 1, j[0], 0);
    waited = 0;
    while (!(in_frame && rises >= 4) && waited < LIM) begin
      @(negedge clk);
      waited++;
    end
    check("rst_mid_reached", in_frame && rises >= 4, 1);
    rst = 1;
    #1;
    check("rst_mid_cs_n", cs_n, 1);
    check("rst_mid_sclk", sclk, 0);
    check("rst_mid_mosi", mosi, 0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 0;
    rx_q.delete();
    check("rst_mid_fin", fin_state, 0);
    idle(3 * FRAME);
    check("rst_mid_no_frame", rx_q.size(), 0);
    check("rst_mid_cs_idle", cs_n, 1);
    check("rst_mid_ready", bit_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
